// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key input conditioner and later keypad blocks:
// debounce FSM state encoding and the pin polarity helper.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_t;

    // Map a raw pin level to "pressed" (1) given the board polarity.
    function automatic logic pin_to_pressed(input logic pin, input logic active_low);
        return pin ^ active_low;
    endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs.
// RESET_VAL is the pin level assumed while in reset (normally the idle level).
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; only q is safe to use in the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises the raw pin, debounces it and emits a
// stable level plus one-cycle press / release / long-press pulses.
// Optional feature macro: KEY_LONG_PRESS_EN builds the hold counter and key_long;
// without it key_long is tied low and LONG_CYC has no effect.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | released and stable, waiting for a pressed sample
//   PRESS_CHK | pressed seen, counting stable samples before accepting
//   HELD      | press accepted, key_level high, hold time accumulating
//   REL_CHK   | released seen while held, counting before accepting release
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 480_000,
    parameter int LONG_CYC     = 24_000_000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_pressed,
    output logic key_released,
    output logic key_long
);

    localparam int              DEB_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    if (DEBOUNCE_CYC < 2 || LONG_CYC < 1) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYC must be >= 2 and LONG_CYC >= 1");
    end

    logic             key_sync;
    logic             p;
    key_state_t       state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_d, pressed_d, released_d;
    logic             hold_clr;

    // Reset value of the synchroniser is the released pin level, which equals ACTIVE_LOW.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (key_sync)
    );

    assign p = pin_to_pressed(key_sync, ACTIVE_LOW);

    // State, debounce counter and registered level / edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            deb_cnt_q    <= '0;
            key_level    <= 1'b0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            key_level    <= level_d;
            key_pressed  <= pressed_d;
            key_released <= released_d;
        end
    end

    // Next-state and next-output decode; any contrary sample restarts the check.
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        level_d    = key_level;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        hold_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (p) begin
                    state_d   = PRESS_CHK;
                    deb_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = HELD;
                    pressed_d = 1'b1;
                    level_d   = 1'b1;
                    hold_clr  = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            HELD: begin
                if (!p) begin
                    state_d   = REL_CHK;
                    deb_cnt_d = '0;
                end
            end
            REL_CHK: begin
                if (p) begin
                    state_d = HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = IDLE;
                    released_d = 1'b1;
                    level_d    = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int               HOLD_W    = $clog2(LONG_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYC - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              long_q;

    // Hold time counts only HELD cycles and saturates, so key_long fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= (state_q == HELD) && (hold_cnt == HOLD_FIRE);
            if (hold_clr) begin
                hold_cnt <= '0;
            end else if (state_q == HELD && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    assign key_long = long_q;
`else
    assign key_long = 1'b0;
`endif

endmodule
